pcfx_bus_ctrl: RTL and testbench

Controller for the V810 external memory bus: decodes each bus cycle to a region, drives chip selects, `READYn` after a per-region number of wait states, and `SZRQn` for 16-bit devices. It arbitrates bus ownership between the CPU bus interface and one hold requester (DMA), using a hold-request/acknowledge handshake. It replaces ad-hoc chip-select/ready glue between the CPU memory interface and the ROM/RAM devices.

---
 rtl/pcfx_bus_pkg.sv | 34 +++
 rtl/pcfx_bus_decode.sv | 11 +
 rtl/pcfx_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pcfx_bus_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcfx_bus_pkg.sv
// Shared types and decode helpers for the PC-FX V810 external bus controller.
package pcfx_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_ROM  = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [11:0] ROM_BASE = 12'hFFF;

    // Only A[31:20] takes part in decode, so callers pass just those bits.
    function automatic region_e region_of(input logic [11:0] a_hi);
        if (a_hi == ROM_BASE)
            return REG_ROM;
        else if (!a_hi[11])
            return REG_RAM;
        else
            return REG_NONE;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pcfx_bus_decode.sv
// Combinational address-to-region decode for the external bus.
module pcfx_bus_decode
    import pcfx_bus_pkg::*;
(
    input  logic [11:0] addr_hi,
    output region_e     region
);

    assign region = region_of(addr_hi);

endmodule

// File: rtl/pcfx_bus_ctrl.sv
// V810 external bus controller: chip selects, wait-state READYn/SZRQn/BERR
// generation and CPU/DMA bus ownership via HLDRQ/HLDAK.
module pcfx_bus_ctrl
    import pcfx_bus_pkg::*;
#(
    parameter int ROM_WAIT = 2,
    parameter int RAM_WAIT = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic        MRQn,
    input  logic        BCYSTn,
    input  logic        RW,
    output logic        READYn,
    output logic        SZRQn,
    output logic        ROM_CEn,
    output logic        RAM_CEn,
    output logic        BERR,
    input  logic        HLDRQ,
    output logic        HLDAK,
    output logic        BUSY
);

    localparam int MAX_WAIT = max3(ROM_WAIT, RAM_WAIT, TIMEOUT);
    localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t wait_of(input region_e r);
        case (r)
            REG_ROM: return cnt_t'(ROM_WAIT);
            REG_RAM: return cnt_t'(RAM_WAIT);
            default: return cnt_t'(TIMEOUT);
        endcase
    endfunction

    state_e      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    region_e     region_q, region_d;
    logic        cyc_rw_q, cyc_rw_d;
    logic        pend_q, pend_d;
    logic [11:0] pend_addr_q, pend_addr_d;
    logic        pend_rw_q, pend_rw_d;

    logic readyn_q, readyn_d;
    logic szrqn_q, szrqn_d;
    logic rom_cen_q, rom_cen_d;
    logic ram_cen_q, ram_cen_d;
    logic berr_q, berr_d;
    logic hldak_q, hldak_d;
    logic busy_q, busy_d;

    logic        start, use_pend, launch, latch, in_ready;
    logic [11:0] dec_addr;
    region_e     dec_region;

    // Direction and low address bits travel with the cycle but drive no output.
    logic unused_bits;
    assign unused_bits = ^{A[19:0], cyc_rw_q};

    assign start    = !BCYSTn && !MRQn;
    // A cycle held back during HOLD decodes from its latched address.
    assign use_pend = (state_q == ST_IDLE) && pend_q;
    assign dec_addr = use_pend ? pend_addr_q : A[31:20];

    pcfx_bus_decode u_decode (
        .addr_hi (dec_addr),
        .region  (dec_region)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            region_q    <= REG_RAM;
            cyc_rw_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_rw_q   <= 1'b0;
            readyn_q    <= 1'b1;
            szrqn_q     <= 1'b1;
            rom_cen_q   <= 1'b1;
            ram_cen_q   <= 1'b1;
            berr_q      <= 1'b0;
            hldak_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else if (CE) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            region_q    <= region_d;
            cyc_rw_q    <= cyc_rw_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_rw_q   <= pend_rw_d;
            readyn_q    <= readyn_d;
            szrqn_q     <= szrqn_d;
            rom_cen_q   <= rom_cen_d;
            ram_cen_q   <= ram_cen_d;
            berr_q      <= berr_d;
            hldak_q     <= hldak_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        region_d    = region_q;
        cyc_rw_d    = cyc_rw_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_rw_d   = pend_rw_q;
        launch      = 1'b0;
        latch       = 1'b0;

        case (state_q)
            // A pending cycle goes first so the CPU gets one cycle between holds.
            ST_IDLE: begin
                if (pend_q) begin
                    launch = 1'b1;
                end else if (HLDRQ) begin
                    state_d = ST_HOLD;
                    latch   = start;
                end else begin
                    launch = start;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    launch  = start;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            ST_HOLD: begin
                latch = start;
                if (!HLDRQ) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d  = ST_WAIT;
            region_d = dec_region;
            cnt_d    = wait_of(dec_region);
            cyc_rw_d = use_pend ? pend_rw_q : RW;
            pend_d   = 1'b0;
        end
        if (latch) begin
            pend_d      = 1'b1;
            pend_addr_d = A[31:20];
            pend_rw_d   = RW;
        end
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        in_ready  = (state_d == ST_WAIT) && (cnt_d == '0);
        readyn_d  = !in_ready;
        szrqn_d   = !(in_ready && region_d == REG_ROM);
        berr_d    = in_ready && region_d == REG_NONE;
        rom_cen_d = !(state_d == ST_WAIT && region_d == REG_ROM);
        ram_cen_d = !(state_d == ST_WAIT && region_d == REG_RAM);
        hldak_d   = (state_d == ST_HOLD);
        busy_d    = (state_d == ST_WAIT) || pend_d;
    end

    assign READYn  = readyn_q;
    assign SZRQn   = szrqn_q;
    assign ROM_CEn = rom_cen_q;
    assign RAM_CEn = ram_cen_q;
    assign BERR    = berr_q;
    assign HLDAK   = hldak_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_pcfx_bus_ctrl.sv
// Self-checking bench for pcfx_bus_ctrl: timeline model plus directed literal checks.
module tb_pcfx_bus_ctrl;

    localparam int ROM_W = 2;
    localparam int RAM_W = 0;
    localparam int TMO_W = 15;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        CE = 1'b1;
    logic [31:0] A = '0;
    logic        MRQn = 1'b1;
    logic        BCYSTn = 1'b1;
    logic        RW = 1'b1;
    logic        HLDRQ = 1'b0;
    logic        READYn, SZRQn, ROM_CEn, RAM_CEn, BERR, HLDAK, BUSY;

    int n_chk = 0;
    int n_err = 0;

    pcfx_bus_ctrl #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .TIMEOUT(TMO_W)) dut (
        .CLK(CLK), .RES(RES), .CE(CE), .A(A), .MRQn(MRQn), .BCYSTn(BCYSTn),
        .RW(RW), .READYn(READYn), .SZRQn(SZRQn), .ROM_CEn(ROM_CEn),
        .RAM_CEn(RAM_CEn), .BERR(BERR), .HLDRQ(HLDRQ), .HLDAK(HLDAK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Timeline model: output cycle index m_t counts CE edges; a cycle started at
    // index c holds its chip select through index c+W and signals ready there.
    int m_t, m_ready_at, m_reg, m_pend_reg;
    bit m_active, m_hold, m_pend;

    function automatic int region(input logic [31:0] a);
        if (a >= 32'hFFF0_0000) return 1;
        if (a < 32'h8000_0000) return 0;
        return 2;
    endfunction

    function automatic int wait_for(input int r);
        return (r == 1) ? ROM_W : (r == 0) ? RAM_W : TMO_W;
    endfunction

    always @(posedge CLK or posedge RES) begin
        if (RES) begin
            m_t = 0; m_active = 0; m_hold = 0; m_pend = 0;
            m_ready_at = 0; m_reg = 0; m_pend_reg = 0;
        end else if (CE) begin
            int  c, r;
            bit  start, fin;
            c     = m_t + 1;
            start = !BCYSTn && !MRQn;
            r     = region(A);
            fin   = m_active && (m_t == m_ready_at);
            if (m_active && !fin) begin
            end else if (fin) begin
                m_active = 0;
                if (start) begin m_active = 1; m_reg = r; m_ready_at = c + wait_for(r); end
            end else if (m_hold) begin
                if (start) begin m_pend = 1; m_pend_reg = r; end
                if (!HLDRQ) m_hold = 0;
            end else if (m_pend) begin
                m_active = 1; m_reg = m_pend_reg; m_ready_at = c + wait_for(m_pend_reg);
                m_pend = 0;
            end else if (HLDRQ) begin
                m_hold = 1;
                if (start) begin m_pend = 1; m_pend_reg = r; end
            end else if (start) begin
                m_active = 1; m_reg = r; m_ready_at = c + wait_for(r);
            end
            m_t = c;
        end
    end

    always @(negedge CLK) begin
        bit rdy;
        rdy = m_active && (m_t == m_ready_at);
        chk("READYn",  READYn,  !rdy);
        chk("SZRQn",   SZRQn,   !(rdy && m_reg == 1));
        chk("BERR",    BERR,    rdy && m_reg == 2);
        chk("ROM_CEn", ROM_CEn, !(m_active && m_reg == 1));
        chk("RAM_CEn", RAM_CEn, !(m_active && m_reg == 0));
        chk("HLDAK",   HLDAK,   m_hold);
        chk("BUSY",    BUSY,    m_active || m_pend);
    end

    // Drive a one-cycle start strobe; returns at the first cycle after the sampling edge.
    task automatic start_cyc(input logic [31:0] a);
        BCYSTn = 1'b0; MRQn = 1'b0; A = a; RW = 1'b1;
        @(negedge CLK);
        BCYSTn = 1'b1; MRQn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [31:0] pick_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 4) return {1'b0, 31'($urandom)};
        if (k < 8) return {12'hFFF, 20'($urandom)};
        return 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
    endfunction

    initial begin
        idle(2);
        chk("rst_READYn", READYn, 1'b1);
        chk("rst_ROM_CEn", ROM_CEn, 1'b1);
        chk("rst_RAM_CEn", RAM_CEn, 1'b1);
        chk("rst_BUSY", BUSY, 1'b0);
        RES = 1'b0;
        idle(2);

        // RAM, zero wait states
        start_cyc(32'h0000_0100);
        chk("ram_cs", RAM_CEn, 1'b0);
        chk("ram_rdy", READYn, 1'b0);
        chk("ram_szrq", SZRQn, 1'b1);
        idle(1);
        chk("ram_rdy_end", READYn, 1'b1);
        chk("ram_cs_end", RAM_CEn, 1'b1);
        idle(2);

        // ROM, two wait states
        start_cyc(32'hFFF0_0000);
        chk("rom_cs1", ROM_CEn, 1'b0);
        chk("rom_rdy1", READYn, 1'b1);
        idle(2);
        chk("rom_rdy3", READYn, 1'b0);
        chk("rom_szrq3", SZRQn, 1'b0);
        chk("rom_cs3", ROM_CEn, 1'b0);
        idle(1);
        chk("rom_cs_end", ROM_CEn, 1'b1);
        idle(2);

        // Unmapped access times out
        start_cyc(32'h8000_0000);
        idle(14);
        chk("none_rdy15", READYn, 1'b1);
        idle(1);
        chk("none_rdy16", READYn, 1'b0);
        chk("none_berr16", BERR, 1'b1);
        chk("none_cs16", ROM_CEn & RAM_CEn, 1'b1);
        idle(1);
        chk("none_berr17", BERR, 1'b0);
        idle(2);

        // Hold request beats a simultaneous start; pending cycle runs before the next grant
        HLDRQ = 1'b1; BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_0200;
        @(negedge CLK);
        chk("hold_ak", HLDAK, 1'b1);
        chk("hold_busy", BUSY, 1'b1);
        chk("hold_cs", RAM_CEn, 1'b1);
        BCYSTn = 1'b1; MRQn = 1'b1; HLDRQ = 1'b0;
        @(negedge CLK);
        chk("hold_ak_drop", HLDAK, 1'b0);
        chk("hold_pend_busy", BUSY, 1'b1);
        HLDRQ = 1'b1;
        @(negedge CLK);
        chk("pend_cs", RAM_CEn, 1'b0);
        chk("pend_rdy", READYn, 1'b0);
        chk("pend_noak", HLDAK, 1'b0);
        @(negedge CLK);
        chk("pend_done_ak", HLDAK, 1'b0);
        chk("pend_done_busy", BUSY, 1'b0);
        @(negedge CLK);
        chk("regrant_ak", HLDAK, 1'b1);
        HLDRQ = 1'b0;
        idle(1);
        chk("regrant_drop", HLDAK, 1'b0);
        idle(2);

        // Back-to-back RAM cycles
        BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("b2b_rdy", READYn, 1'b0);
            chk("b2b_cs", RAM_CEn, 1'b0);
            A = A + 32'h4;
        end
        BCYSTn = 1'b1; MRQn = 1'b1;
        idle(3);

        // Reset mid ROM cycle
        start_cyc(32'hFFF1_2340);
        @(negedge CLK);
        #2 RES = 1'b1;
        #1;
        chk("rst_mid_cs", ROM_CEn, 1'b1);
        chk("rst_mid_rdy", READYn, 1'b1);
        chk("rst_mid_busy", BUSY, 1'b0);
        @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);
        chk("rst_mid_noready", READYn, 1'b1);
        start_cyc(32'hFFF0_0010);
        idle(2);
        chk("rst_after_rdy", READYn, 1'b0);
        idle(2);

        // CE gating during ROM wait
        start_cyc(32'hFFF0_0020);
        CE = 1'b0; @(negedge CLK);
        chk("ce_rdy_a", READYn, 1'b1);
        CE = 1'b1; @(negedge CLK);
        chk("ce_rdy_b", READYn, 1'b1);
        CE = 1'b0; @(negedge CLK);
        chk("ce_rdy_c", READYn, 1'b1);
        CE = 1'b1; @(negedge CLK);
        chk("ce_rdy_d", READYn, 1'b0);
        chk("ce_cs_d", ROM_CEn, 1'b0);
        @(negedge CLK);
        chk("ce_rdy_e", READYn, 1'b1);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit can;
            CE = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) HLDRQ = !HLDRQ;
            can = !m_pend && (!m_active || m_t == m_ready_at);
            if (can && $urandom_range(0, 2) == 0) begin
                BCYSTn = 1'b0;
                MRQn   = ($urandom_range(0, 7) == 0);
                A      = pick_addr();
                RW     = 1'($urandom);
            end else begin
                BCYSTn = 1'b1;
                MRQn   = 1'($urandom);
            end
            @(negedge CLK);
        end
        BCYSTn = 1'b1; MRQn = 1'b1; HLDRQ = 1'b0; CE = 1'b1;
        idle(25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
